// File: rtl/bcd_serial_addsub.sv
// Digit-serial packed-BCD adder/subtractor: one digit per clock, LSD first.
// Optional macro BCD_INVALID_CHECK_EN flags operands containing nibbles above 9.
module bcd_serial_addsub #(
    parameter int unsigned DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  op,
    input  logic [4*DIGITS-1:0]   a,
    input  logic [4*DIGITS-1:0]   b,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   result,
    output logic                  cout,
    output logic                  err
);
    localparam int unsigned W    = 4 * DIGITS;
    localparam logic [4:0]  LAST = 5'(DIGITS - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t         state;
    logic [W-1:0]   a_sh;
    logic [W-1:0]   b_sh;
    logic [W-1:0]   acc;
    logic           op_q;
    logic           carry;
    logic [4:0]     idx;

    logic [3:0]     bd;
    logic [4:0]     s;
    logic [3:0]     digit;
    logic           carry_nxt;
    logic [W-1:0]   acc_nxt;

    // Single-digit add/sub with decimal correction on the current LSD
    always_comb begin
        bd        = op_q ? 4'(4'd9 - b_sh[3:0]) : b_sh[3:0];
        s         = 5'(a_sh[3:0]) + 5'(bd) + 5'(carry);
        digit     = s[3:0];
        carry_nxt = 1'b0;
        if (s > 5'd9) begin
            digit     = 4'(s + 5'd6);
            carry_nxt = 1'b1;
        end
        // New digit enters at the top; after DIGITS shifts digit 0 sits at the bottom
        acc_nxt = (acc >> 4) | (W'(digit) << (W - 4));
    end

`ifdef BCD_INVALID_CHECK_EN
    logic has_bad;
    logic inv;

    always_comb begin
        has_bad = 1'b0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (a[4*i +: 4] > 4'd9 || b[4*i +: 4] > 4'd9)
                has_bad = 1'b1;
        end
    end
`else
    assign err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            a_sh   <= '0;
            b_sh   <= '0;
            acc    <= '0;
            op_q   <= 1'b0;
            carry  <= 1'b0;
            idx    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            cout   <= 1'b0;
`ifdef BCD_INVALID_CHECK_EN
            inv    <= 1'b0;
            err    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        op_q  <= op;
                        carry <= op;
                        idx   <= '0;
                        acc   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
`ifdef BCD_INVALID_CHECK_EN
                        inv   <= has_bad;
`endif
                    end
                end
                RUN: begin
                    a_sh  <= a_sh >> 4;
                    b_sh  <= b_sh >> 4;
                    acc   <= acc_nxt;
                    carry <= carry_nxt;
                    idx   <= idx + 5'd1;
                    if (idx == LAST) begin
                        state  <= DONE;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        result <= acc_nxt;
                        cout   <= carry_nxt;
`ifdef BCD_INVALID_CHECK_EN
                        err    <= inv;
                        if (inv) begin
                            result <= '0;
                            cout   <= 1'b0;
                        end
`endif
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/bcd_serial_addsub.md
Name: bcd_serial_addsub

Overview:
- Digit-serial, multi-digit packed-BCD adder/subtractor. Processes one BCD digit per clock, least-significant digit first.
- Reuses the single-digit add/sub-with-decimal-correction arithmetic of the existing digit stage, sequenced over DIGITS nibbles.
- Sits upstream of the display/result register path: accepts full operands with a start pulse and returns a packed N-digit result plus decimal carry/no-borrow.

Parameters:
- DIGITS, 4: number of BCD digits per operand. Legal range 1..16.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE
- op  input  1  0 = A+B, 1 = A-B (10's complement)
- a  input  4*DIGITS  packed BCD operand A; digit 0 in bits [3:0]
- b  input  4*DIGITS  packed BCD operand B
- busy  output  1  high while digits are being processed
- done  output  1  one-cycle completion pulse
- result  output  4*DIGITS  packed BCD result; updated only at completion
- cout  output  1  decimal carry out (add) / no-borrow flag (sub)
- err  output  1  invalid-digit flag (see Optional Feature)

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, busy=0, done=0, result=0, cout=0, err=0, internal index/carry/operand registers cleared.
- Reset asserted mid-operation aborts immediately. After release, the block is in IDLE with result=0 and emits no done.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - On start=1 at edge E0: latch a, b, op; idx=0; carry=op; go to RUN; busy=1.
  - start=0: stay in IDLE.
- RUN: each edge processes digit idx:
  - bd = op ? (9 - b[idx]) : b[idx]
  - s = a[idx] + bd + carry (5-bit)
  - if s > 9: digit = (s+6)[3:0], carry = 1; else digit = s[3:0], carry = 0
  - digit is written into an internal shift accumulator; idx increments.
- Completion: on the edge that processes digit DIGITS-1 (edge E0+DIGITS):
  - result <= accumulator including the last digit
  - cout <= final carry
  - state -> DONE; busy=0; done=1
- DONE: lasts exactly one cycle, then returns to IDLE; done=0. result/cout hold until the next completion.
- Latency: done first visible DIGITS cycles after the start edge. Throughput: one operation per DIGITS+2 cycles.
- start is ignored in RUN and DONE; there is no queueing. Operand inputs are don't-care after E0.
- Subtract: result = A - B mod 10^DIGITS.
  - cout=1 means A >= B.
  - cout=0 means negative; result holds the 10's complement.
- Add overflow: result wraps mod 10^DIGITS and cout=1.
- DIGITS=1: RUN lasts one cycle; all rules above unchanged.
- err=0 at all times when the feature is absent.

Optional Feature:
- Macro: BCD_INVALID_CHECK_EN
- Defined:
  - At E0, any latched nibble of a or b greater than 9 sets an internal invalid flag.
  - The operation still runs the full DIGITS cycles; latency is unchanged.
  - At completion: result <= 0, cout <= 0, err <= 1.
  - A valid operation clears err at its completion. err is also cleared by reset.
- Not defined: no nibble check. Invalid nibbles propagate through the correction arithmetic unchecked, and err is tied 0.

Test Plan (DIGITS=4):
- Add: a=0x1234, b=0x5678, op=0, start pulse -> done 4 cycles later; result=0x6912, cout=0; busy high for exactly 4 cycles.
- Add wrap: a=0x9999, b=0x0001, op=0 -> result=0x0000, cout=1. Then a=0x0000, b=0x0000 -> result=0x0000, cout=0.
- Subtract: a=0x5000, b=0x1234, op=1 -> result=0x3766, cout=1. Then a=0x1234, b=0x5000, op=1 -> result=0x6234, cout=0.
- Start during busy: start at E0 (0x1111+0x2222), second start at E0+2 with different operands -> single done at E0+4, result=0x3333, second request ignored; result stable (previous value) throughout RUN.
- Reset mid-op: start 0x4444+0x4444, drop rst_n at E0+2 for one cycle -> outputs immediately 0, no done pulse. A fresh start after release completes normally with result=0x8888.
- With BCD_INVALID_CHECK_EN: a=0x00A0, b=0x0001, op=0 -> done at E0+4, result=0x0000, cout=0, err=1. Next valid op 0x0001+0x0001 -> result=0x0002, err=0.
